// File: rtl/adder_err_sweep_pkg.sv
// Shared types and width helpers for the approximate-adder error sweep.
package adder_err_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int cnt_width(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sum_width(input int w);
    return 3 * w + 1;
  endfunction

  function automatic int bias_width(input int w);
    return 3 * w + 2;
  endfunction

endpackage

// File: rtl/adder_err_sweep_acc.sv
// Stage-2 error accumulators: error count, max |err|, sum |err| and,
// with ADDER_ERR_SWEEP_BIAS_EN, the signed error sum.
module adder_err_sweep_acc
  import adder_err_sweep_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         valid,
  input  logic signed [W+1:0]          err,
  output logic [cnt_width(W)-1:0]      err_count,
  output logic [W:0]                   max_abs_err,
  output logic [sum_width(W)-1:0]      sum_abs_err
`ifdef ADDER_ERR_SWEEP_BIAS_EN
  ,
  output logic [bias_width(W)-1:0]     bias_sum
`endif
);

  localparam int CW = cnt_width(W);
  localparam int SW = sum_width(W);

  // |err| always fits W+1 bits: the most negative error is -(2^(W+1)-1).
  logic [W:0] abs_err;
  assign abs_err = err[W+1] ? (~err[W:0] + (W+1)'(1)) : err[W:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count   <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
    end else if (clear) begin
      err_count   <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
    end else if (valid) begin
      err_count   <= err_count + CW'(err != '0);
      sum_abs_err <= sum_abs_err + {{(SW-W-1){1'b0}}, abs_err};
      if (abs_err > max_abs_err) max_abs_err <= abs_err;
    end
  end

`ifdef ADDER_ERR_SWEEP_BIAS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      bias_sum <= '0;
    else if (clear)  bias_sum <= '0;
    else if (valid)  bias_sum <= bias_sum + {{(2*W){err[W+1]}}, err};
  end
`endif

endmodule

// File: rtl/adder_err_sweep_ctrl.sv
// Exhaustive sweep sequencer for an approximate adder: drives every operand
// pair, captures the error against the exact sum, and accumulates statistics.
// Optional signed bias accumulator enabled by ADDER_ERR_SWEEP_BIAS_EN.
module adder_err_sweep_ctrl
  import adder_err_sweep_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         hold,
  output logic [W-1:0]                 op_a,
  output logic [W-1:0]                 op_b,
  input  logic [W:0]                   dut_sum,
  output logic                         busy,
  output logic                         done,
  output logic [cnt_width(W)-1:0]      err_count,
  output logic [W:0]                   max_abs_err,
  output logic [sum_width(W)-1:0]      sum_abs_err
`ifdef ADDER_ERR_SWEEP_BIAS_EN
  ,
  output logic [bias_width(W)-1:0]     bias_sum
`endif
);

  localparam int PW = 2 * W;

  state_t               state, state_nxt;
  logic [PW-1:0]        cnt, cnt_nxt;
  logic                 s1_valid, s1_valid_nxt;
  logic signed [W+1:0]  s1_err, s1_err_nxt;
  logic                 acc_clear;
  logic [W:0]           exact_sum;
  logic [W+1:0]         err_raw;

  assign op_a = cnt[W-1:0];
  assign op_b = cnt[PW-1:W];
  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  assign exact_sum = {1'b0, op_a} + {1'b0, op_b};
  assign err_raw   = {1'b0, exact_sum} - {1'b0, dut_sum};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_err   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      s1_valid <= s1_valid_nxt;
      s1_err   <= s1_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    s1_valid_nxt = 1'b0;
    s1_err_nxt   = s1_err;
    acc_clear    = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            acc_clear = 1'b1;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            s1_valid_nxt = 1'b1;
            s1_err_nxt   = signed'(err_raw);
            cnt_nxt      = cnt + PW'(1);
            // Last pair consumed; counter wraps to 0 and is not reused.
            if (cnt == '1) state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  adder_err_sweep_acc #(.W(W)) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (acc_clear),
    .valid       (s1_valid),
    .err         (s1_err),
    .err_count   (err_count),
    .max_abs_err (max_abs_err),
    .sum_abs_err (sum_abs_err)
`ifdef ADDER_ERR_SWEEP_BIAS_EN
    ,
    .bias_sum    (bias_sum)
`endif
  );

endmodule

// File: tb/tb_adder_err_sweep_ctrl.sv
// Directed bench for adder_err_sweep_ctrl at W=4 (256 pairs) with a behavioural
// approximate adder; totals are hand-derived from the sum distribution of 0..15.
module tb_adder_err_sweep_ctrl;

  localparam int W = 4;
  localparam int N = 256;

  logic           clk = 1'b0;
  logic           rst_n, start, abort, hold;
  logic [W-1:0]   op_a, op_b;
  logic [W:0]     dut_sum;
  logic           busy, done;
  logic [2*W:0]   err_count;
  logic [W:0]     max_abs_err;
  logic [3*W:0]   sum_abs_err;
`ifdef ADDER_ERR_SWEEP_BIAS_EN
  logic [3*W+1:0] bias_sum;
`endif

  int checks   = 0;
  int failures = 0;
  int mode     = 0;  // 0 exact, 1 low 3 bits zeroed, 2 stuck at 0, 3 sum|1

  always #5 clk = ~clk;

  adder_err_sweep_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .hold        (hold),
    .op_a        (op_a),
    .op_b        (op_b),
    .dut_sum     (dut_sum),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .max_abs_err (max_abs_err),
    .sum_abs_err (sum_abs_err)
`ifdef ADDER_ERR_SWEEP_BIAS_EN
    ,
    .bias_sum    (bias_sum)
`endif
  );

  logic [W:0] exact;
  always_comb begin
    exact = {1'b0, op_a} + {1'b0, op_b};
    case (mode)
      1:       dut_sum = exact & 5'b11000;
      2:       dut_sum = '0;
      3:       dut_sum = exact | 5'd1;
      default: dut_sum = exact;
    endcase
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bias(input string tag, input longint exp);
`ifdef ADDER_ERR_SWEEP_BIAS_EN
    logic signed [63:0] b;
    b = $signed(bias_sum);
    chk(tag, b, exp);
`endif
  endtask

  // Launch a sweep and step until done (bounded). Pair k is expected on
  // op_* in cycle k+1 when holds are off.
  task automatic run_sweep(input bit toggle_hold, input int stray_start,
                           output int busy_cyc, output int done_cyc,
                           output bit seq_ok);
    int cyc;
    logic [2*W-1:0] exp_pair;
    busy_cyc = 0;
    done_cyc = 0;
    seq_ok   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 2000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy) busy_cyc++;
      hold  = toggle_hold && (cyc % 2 == 1);
      start = (cyc == stray_start);
      if (!toggle_hold && cyc <= N) begin
        exp_pair = (2*W)'(cyc - 1);
        if ({op_b, op_a} !== exp_pair) seq_ok = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  int busy_cyc, done_cyc;
  bit seq_ok, saw_done, saw_busy;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ops", {op_b, op_a}, 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_sum", sum_abs_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Truncation model: 224 nonzero errors, max 7, sum 896, bias +896.
    mode = 1;
    run_sweep(1'b0, 0, busy_cyc, done_cyc, seq_ok);
    chk("trunc_done_cyc", done_cyc, N + 2);
    chk("trunc_busy", busy_cyc, N + 1);
    chk("trunc_seq", seq_ok, 1);
    chk("trunc_cnt", err_count, 224);
    chk("trunc_max", max_abs_err, 7);
    chk("trunc_sum", sum_abs_err, 896);
    chk_bias("trunc_bias", 896);
    repeat (5) @(posedge clk);
    #1;
    chk("trunc_done_held", done, 1);
    chk("trunc_cnt_held", err_count, 224);

    // Exact model from DONE: accumulators must clear on start.
    mode = 0;
    run_sweep(1'b0, 0, busy_cyc, done_cyc, seq_ok);
    chk("exact_busy", busy_cyc, N + 1);
    chk("exact_seq", seq_ok, 1);
    chk("exact_cnt", err_count, 0);
    chk("exact_max", max_abs_err, 0);
    chk("exact_sum", sum_abs_err, 0);
    chk_bias("exact_bias", 0);

    // Stuck at 0, with a stray start mid-run that must be ignored.
    mode = 2;
    run_sweep(1'b0, 50, busy_cyc, done_cyc, seq_ok);
    chk("stuck_busy", busy_cyc, N + 1);
    chk("stuck_cnt", err_count, 255);
    chk("stuck_max", max_abs_err, 30);
    chk("stuck_sum", sum_abs_err, 3840);
    chk_bias("stuck_bias", 3840);

    // Over-estimating model: error -1 on every even sum (128 pairs).
    mode = 3;
    run_sweep(1'b0, 0, busy_cyc, done_cyc, seq_ok);
    chk("neg_cnt", err_count, 128);
    chk("neg_max", max_abs_err, 1);
    chk("neg_sum", sum_abs_err, 128);
    chk_bias("neg_bias", -128);

    // Hold on every odd cycle of RUN: one pair per two cycles.
    mode = 1;
    run_sweep(1'b1, 0, busy_cyc, done_cyc, seq_ok);
    chk("hold_busy", busy_cyc, 2 * N + 1);
    chk("hold_done_cyc", done_cyc, 2 * N + 2);
    chk("hold_cnt", err_count, 224);
    chk("hold_max", max_abs_err, 7);
    chk("hold_sum", sum_abs_err, 896);
    chk_bias("hold_bias", 896);

    // Abort in cycle 100, then a full rerun.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_no_busy", saw_busy, 0);
    run_sweep(1'b0, 0, busy_cyc, done_cyc, seq_ok);
    chk("rerun_cnt", err_count, 224);
    chk("rerun_max", max_abs_err, 7);
    chk("rerun_sum", sum_abs_err, 896);
    chk_bias("rerun_bias", 896);

    // One-cycle reset mid-run.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ops", {op_b, op_a}, 0);
    chk("mrst_cnt", err_count, 0);
    chk("mrst_max", max_abs_err, 0);
    chk("mrst_sum", sum_abs_err, 0);
    chk_bias("mrst_bias", 0);

    // start together with abort: no run.
    start = 1'b1;
    abort = 1'b1;
    saw_busy = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || done) saw_busy = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;
    if (busy || done) saw_busy = 1'b1;
    chk("start_abort_idle", saw_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
